// File: rtl/tag_dispatch_if.sv
// tag_dispatch_if: input-FIFO read side plus per-flux destination write side of tag_dispatch.
interface tag_dispatch_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int TAG_WIDTH  = $clog2(FLUX)
);
  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_dout;
  logic                            in_empty;
  logic                            in_read;
  logic [FLUX*DATA_WIDTH-1:0]      out_din;
  logic [FLUX-1:0]                 out_write;
  logic [FLUX-1:0]                 out_full;

  modport master (
    output in_dout, in_empty, out_full,
    input  in_read, out_din, out_write
  );

  modport slave (
    input  in_dout, in_empty, out_full,
    output in_read, out_din, out_write
  );
endinterface

// File: rtl/tag_dispatch.sv
// tag_dispatch: routes tagged tokens from one input FIFO to FLUX destination FIFOs via one-entry holds.
// Statistics counters (tok_cnt, drop_cnt) exist only when TAG_DISPATCH_STATS_EN is defined.
`default_nettype none

module tag_dispatch #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FLUX       = 2,
  parameter  int CNT_WIDTH  = 16,
  localparam int TAG_WIDTH  = $clog2(FLUX)
) (
  input  logic                      clk,
  input  logic                      rst,
  tag_dispatch_if.slave             bus,
  output logic                      bad_tag,
  output logic [FLUX*CNT_WIDTH-1:0] tok_cnt,
  output logic [CNT_WIDTH-1:0]      drop_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } hold_state_e;

  localparam logic [TAG_WIDTH:0] FLUX_L = (TAG_WIDTH+1)'(FLUX);

  hold_state_e           state_q     [FLUX];
  logic [DATA_WIDTH-1:0] hold_data_q [FLUX];
  logic                  run_q;
  logic                  bad_tag_q;

  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] payload;
  logic                  tag_bad;
  logic [FLUX-1:0]       hold_v;
  logic [FLUX-1:0]       drain;
  logic [FLUX-1:0]       sel;
  logic [FLUX-1:0]       push;
  logic                  head_ok;
  logic                  pop;

  assign tag     = bus.in_dout[DATA_WIDTH +: TAG_WIDTH];
  assign payload = bus.in_dout[DATA_WIDTH-1:0];
  assign tag_bad = {1'b0, tag} >= FLUX_L;

  generate
    for (genvar g = 0; g < FLUX; g++) begin : g_flux
      assign hold_v[g] = (state_q[g] == S_FULL);
      assign drain[g]  = hold_v[g] & ~bus.out_full[g];
      assign sel[g]    = (tag == TAG_WIDTH'(g));
      assign push[g]   = pop & sel[g];
      assign bus.out_din[g*DATA_WIDTH +: DATA_WIDTH] = hold_data_q[g];
    end
  endgenerate

  // A head token may leave when it is a discard or its flux has room this cycle.
  assign head_ok       = |(sel & (~hold_v | drain));
  assign pop           = run_q & ~bus.in_empty & (tag_bad | head_ok);
  assign bus.in_read   = pop;
  assign bus.out_write = drain;
  assign bad_tag       = bad_tag_q;

  // run_q gates popping so nothing is read while reset is held low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= 1'b0;
      bad_tag_q <= 1'b0;
      for (int f = 0; f < FLUX; f++) begin
        state_q[f]     <= S_EMPTY;
        hold_data_q[f] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      if (pop && tag_bad) begin
        bad_tag_q <= 1'b1;
      end
      for (int f = 0; f < FLUX; f++) begin
        case (state_q[f])
          S_EMPTY: begin
            if (push[f]) begin
              state_q[f]     <= S_FULL;
              hold_data_q[f] <= payload;
            end
          end
          S_FULL: begin
            if (push[f]) begin
              hold_data_q[f] <= payload;
            end else if (drain[f]) begin
              state_q[f] <= S_EMPTY;
            end
          end
        endcase
      end
    end
  end

`ifdef TAG_DISPATCH_STATS_EN
  logic [CNT_WIDTH-1:0] tok_cnt_q [FLUX];
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
      for (int f = 0; f < FLUX; f++) begin
        tok_cnt_q[f] <= '0;
      end
    end else begin
      if (pop && tag_bad) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
      for (int f = 0; f < FLUX; f++) begin
        if (drain[f]) begin
          tok_cnt_q[f] <= tok_cnt_q[f] + 1'b1;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < FLUX; g++) begin : g_tok_cnt
      assign tok_cnt[g*CNT_WIDTH +: CNT_WIDTH] = tok_cnt_q[g];
    end
  endgenerate
  assign drop_cnt = drop_cnt_q;
`else
  assign tok_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tag_dispatch.sv
// tb_tag_dispatch: vector table, directed corner sequences and a randomized model check of tag_dispatch.
`default_nettype none

module tb_tag_dispatch;

`ifdef TAG_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tag_dispatch_if #(.DATA_WIDTH(8), .FLUX(2)) bus2 ();
  tag_dispatch_if #(.DATA_WIDTH(8), .FLUX(3)) bus3 ();

  logic        bad2, bad3;
  logic [31:0] tok2;
  logic [47:0] tok3;
  logic [15:0] drop2, drop3;

  tag_dispatch #(.DATA_WIDTH(8), .FLUX(2), .CNT_WIDTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .bad_tag(bad2), .tok_cnt(tok2), .drop_cnt(drop2)
  );
  tag_dispatch #(.DATA_WIDTH(8), .FLUX(3), .CNT_WIDTH(16)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .bad_tag(bad3), .tok_cnt(tok3), .drop_cnt(drop3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] cexp(input int v);
    return STATS ? 64'(v & 32'hFFFF) : 64'd0;
  endfunction

  task automatic cyc2(input logic e, input logic t, input logic [7:0] d, input logic [1:0] f);
    @(negedge clk);
    bus2.in_empty = e;
    bus2.in_dout  = {t, d};
    bus2.out_full = f;
    #1;
  endtask

  task automatic chk2(input string nm, input logic er, input logic [1:0] ew, input logic [7:0] ed);
    int lane;
    check({nm, ".in_read"}, 64'(bus2.in_read), 64'(er));
    check({nm, ".out_write"}, 64'(bus2.out_write), 64'(ew));
    if (ew != 2'b00) begin
      lane = ew[1] ? 1 : 0;
      check({nm, ".out_din"}, 64'(bus2.out_din[lane*8 +: 8]), 64'(ed));
    end
  endtask

  task automatic cyc3(input logic e, input logic [1:0] t, input logic [7:0] d, input logic [2:0] f);
    @(negedge clk);
    bus3.in_empty = e;
    bus3.in_dout  = {t, d};
    bus3.out_full = f;
    #1;
  endtask

  typedef struct {
    logic       empty;
    logic       tag;
    logic [7:0] data;
    logic [1:0] full;
    logic       exp_read;
    logic [1:0] exp_write;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [10];

  // Randomized-run reference state for the FLUX=3 instance.
  logic [9:0] src_q [$];
  logic [7:0] exp_q [3][$];
  logic [7:0] got_q [3][$];
  logic       m_hv  [3];
  logic [7:0] m_hd  [3];
  int         m_cnt [3];
  int         m_drop;
  logic       m_bad;

  initial begin
    bus2.in_empty = 1'b1; bus2.in_dout = '0; bus2.out_full = '0;
    bus3.in_empty = 1'b1; bus3.in_dout = '0; bus3.out_full = '0;

    //                empty tag data   full  read write data
    tbl[0] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 2'b00, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h01, 2'b00, 1'b1, 2'b01, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h02, 2'b00, 1'b1, 2'b10, 8'h01};
    tbl[3] = '{1'b0, 1'b1, 8'h03, 2'b00, 1'b1, 2'b01, 8'h02};
    tbl[4] = '{1'b0, 1'b0, 8'h04, 2'b00, 1'b1, 2'b10, 8'h03};
    tbl[5] = '{1'b0, 1'b1, 8'h05, 2'b00, 1'b1, 2'b01, 8'h04};
    tbl[6] = '{1'b0, 1'b0, 8'h06, 2'b00, 1'b1, 2'b10, 8'h05};
    tbl[7] = '{1'b0, 1'b1, 8'h07, 2'b00, 1'b1, 2'b01, 8'h06};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 2'b10, 8'h07};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 8'h00};

    // Reset state, with a non-empty head to show no pop while reset is low.
    #2;
    bus2.in_empty = 1'b0; bus2.in_dout = {1'b1, 8'hAA};
    #1;
    check("rst.in_read", 64'(bus2.in_read), 64'd0);
    check("rst.out_write", 64'(bus2.out_write), 64'd0);
    check("rst.out_din", 64'(bus2.out_din), 64'd0);
    check("rst.bad_tag", 64'(bad2), 64'd0);
    check("rst.tok_cnt", 64'(tok2), 64'd0);
    bus2.in_empty = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single token to flux 1.
    cyc2(1'b0, 1'b1, 8'h5A, 2'b00); chk2("s1.c0", 1'b1, 2'b00, 8'h00);
    cyc2(1'b1, 1'b0, 8'h00, 2'b00); chk2("s1.c1", 1'b0, 2'b10, 8'h5A);
    cyc2(1'b1, 1'b0, 8'h00, 2'b00); chk2("s1.c2", 1'b0, 2'b00, 8'h00);
    check("s1.tok_cnt1", 64'(tok2[31:16]), cexp(1));

    // Alternating stream from the vector table.
    for (int i = 0; i < 10; i++) begin
      cyc2(tbl[i].empty, tbl[i].tag, tbl[i].data, tbl[i].full);
      chk2($sformatf("s2.row%0d", i), tbl[i].exp_read, tbl[i].exp_write, tbl[i].exp_data);
    end
    check("s2.tok_cnt0", 64'(tok2[15:0]), cexp(4));
    check("s2.tok_cnt1", 64'(tok2[31:16]), cexp(5));
    check("s2.drop_cnt", 64'(drop2), 64'd0);

    // Flux 0 destination full: head stalls, tokens for flux 1 behind it wait.
    cyc2(1'b0, 1'b0, 8'h11, 2'b01); chk2("s3.push11", 1'b1, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc2(1'b0, 1'b0, 8'h22, 2'b01); chk2($sformatf("s3.stall%0d", i), 1'b0, 2'b00, 8'h00);
    end
    cyc2(1'b0, 1'b0, 8'h22, 2'b00); chk2("s3.rel", 1'b1, 2'b01, 8'h11);
    cyc2(1'b0, 1'b1, 8'h33, 2'b00); chk2("s3.d22", 1'b1, 2'b01, 8'h22);
    cyc2(1'b1, 1'b0, 8'h00, 2'b00); chk2("s3.d33", 1'b0, 2'b10, 8'h33);
    cyc2(1'b1, 1'b0, 8'h00, 2'b00); chk2("s3.idle", 1'b0, 2'b00, 8'h00);

    // FLUX=3: out-of-range tag is popped and dropped.
    cyc3(1'b0, 2'd3, 8'h44, 3'b000);
    check("s4.bad.in_read", 64'(bus3.in_read), 64'd1);
    check("s4.bad.out_write", 64'(bus3.out_write), 64'd0);
    cyc3(1'b0, 2'd2, 8'h55, 3'b000);
    check("s4.t2.in_read", 64'(bus3.in_read), 64'd1);
    check("s4.t2.out_write", 64'(bus3.out_write), 64'd0);
    check("s4.bad_tag", 64'(bad3), 64'd1);
    check("s4.drop_cnt", 64'(drop3), cexp(1));
    cyc3(1'b1, 2'd0, 8'h00, 3'b000);
    check("s4.d55.out_write", 64'(bus3.out_write), 64'b100);
    check("s4.d55.out_din", 64'(bus3.out_din[23:16]), 64'h55);

    // Reset while flux 0 holds a token.
    cyc2(1'b0, 1'b0, 8'h66, 2'b01); chk2("s5.push", 1'b1, 2'b00, 8'h00);
    cyc2(1'b0, 1'b1, 8'h77, 2'b00); chk2("s5.pre", 1'b1, 2'b01, 8'h66);
    #2 rst = 1'b0;
    #1;
    check("s5.async.out_write", 64'(bus2.out_write), 64'd0);
    check("s5.async.in_read", 64'(bus2.in_read), 64'd0);
    bus2.in_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("s5.tok_cnt", 64'(tok2), 64'd0);
    check("s5.bad_tag3", 64'(bad3), 64'd0);
    check("s5.drop_cnt3", 64'(drop3), 64'd0);
    cyc2(1'b1, 1'b0, 8'h00, 2'b00); chk2("s5.lost", 1'b0, 2'b00, 8'h00);

    // Randomized traffic on FLUX=3 against a reference model.
    for (int f = 0; f < 3; f++) begin
      m_hv[f] = 1'b0; m_hd[f] = 8'h00; m_cnt[f] = 0;
    end
    m_drop = 0; m_bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] t;
      logic [7:0] d;
      t = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      d = 8'($urandom);
      src_q.push_back({t, d});
      if (t != 2'd3) exp_q[t].push_back(d);
    end
    begin
      bit done;
      done = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
        logic       e, exp_pop;
        logic [2:0] fl, exp_wr, act_wr;
        logic [1:0] t;
        logic [7:0] d;
        logic [9:0] head;
        head = (src_q.size() != 0) ? src_q[0] : 10'($urandom);
        t = head[9:8];
        d = head[7:0];
        e  = (src_q.size() == 0) || ($urandom_range(0, 4) == 0);
        fl = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
        @(negedge clk);
        bus3.in_empty = e;
        bus3.in_dout  = head;
        bus3.out_full = fl;
        #1;
        for (int f = 0; f < 3; f++) exp_wr[f] = m_hv[f] && !fl[f];
        exp_pop = !e && (t == 2'd3 || !m_hv[t] || exp_wr[t]);
        act_wr  = bus3.out_write;
        check("rnd.in_read", 64'(bus3.in_read), 64'(exp_pop));
        check("rnd.out_write", 64'(act_wr), 64'(exp_wr));
        check("rnd.bad_tag", 64'(bad3), 64'(m_bad));
        for (int f = 0; f < 3; f++) begin
          if (act_wr[f]) got_q[f].push_back(bus3.out_din[f*8 +: 8]);
          if (exp_wr[f]) begin
            check($sformatf("rnd.out_din%0d", f), 64'(bus3.out_din[f*8 +: 8]), 64'(m_hd[f]));
            m_hv[f] = 1'b0;
            m_cnt[f]++;
          end
        end
        if (exp_pop) begin
          if (t == 2'd3) begin
            m_drop++;
            m_bad = 1'b1;
          end else begin
            m_hv[t] = 1'b1;
            m_hd[t] = d;
          end
          void'(src_q.pop_front());
        end
        done = (src_q.size() == 0) && !m_hv[0] && !m_hv[1] && !m_hv[2];
      end
      check("rnd.completed", 64'(done), 64'd1);
    end
    @(negedge clk);
    bus3.in_empty = 1'b1;
    bus3.out_full = '0;
    #1;
    for (int f = 0; f < 3; f++) begin
      int bad_elems;
      bad_elems = 0;
      check($sformatf("rnd.order_len%0d", f), 64'(got_q[f].size()), 64'(exp_q[f].size()));
      for (int k = 0; k < got_q[f].size() && k < exp_q[f].size(); k++)
        if (got_q[f][k] !== exp_q[f][k]) bad_elems++;
      check($sformatf("rnd.order%0d", f), 64'(bad_elems), 64'd0);
      check($sformatf("rnd.tok_cnt%0d", f), 64'(tok3[f*16 +: 16]), cexp(m_cnt[f]));
    end
    check("rnd.drop_cnt", 64'(drop3), cexp(m_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
